// File: rtl/wm_pkg.sv
// Shared types and constants for the whack-a-mole game blocks.
// Combinational helpers only; no state, no latency.
// No flow control; pure definitions.
package wm_pkg;

  // Round sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_GAP,
    S_LOAD,
    S_ARM,
    S_WAIT,
    S_WIN
  } state_t;

  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Width of the target-mole number sent to the timer
  localparam int RN_W = 2;

  // One LFSR step: shift left, feedback into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  // Low two bits the register will hold after one step from q
  function automatic logic [RN_W-1:0] lfsr_next_lo(input logic [7:0] q);
    return {q[0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wm_lfsr8.sv
// 8-bit Fibonacci LFSR used as the mole picker.
// Advances one step on the clock edge after step is high; q is registered.
// No flow control; step is a plain enable.
module wm_lfsr8
  import wm_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] q
);

  // Shift register: reload seed on reset, otherwise step when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/wm_round_ctrl.sv
// Whack-a-mole round sequencer: picks moles, drives the round timer, scores hits.
// Outputs registered (led decoded from registered state); rn valid one ARM cycle before done counts.
// No backpressure; the timer verdict is a one-cycle done/right strobe honoured only in WAIT.
module wm_round_ctrl
  import wm_pkg::*;
#(
  parameter int         HITS_NEEDED = 5,
  parameter int         GAP_CYCLES  = 50,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alarm_active,
  input  logic            B1,
  input  logic            B2,
  input  logic            B3,
  input  logic            B4,
  input  logic            right,
  input  logic            done,
  output logic [RN_W-1:0] rn,
  output logic            timer_reset,
  output logic            timer_enable,
  output logic [3:0]      led,
  output logic [3:0]      hits,
  output logic [3:0]      misses,
  output logic            alarm_off
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       lfsr_q;
  logic [RN_W-1:0]  pick;
  logic [3:0]       hits_inc;
  logic             any_btn;

  assign any_btn  = B1 | B2 | B3 | B4;
  assign hits_inc = hits + 4'd1;
  // Mole candidate as it will look after this cycle's step
  assign pick     = lfsr_next_lo(lfsr_q);

  wm_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (state == S_LOAD),
    .q     (lfsr_q)
  );

  // Round sequencer: state, counters and registered timer controls
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      gap_cnt      <= '0;
      rn           <= '0;
      hits         <= '0;
      misses       <= '0;
      alarm_off    <= 1'b0;
      timer_enable <= 1'b0;
      timer_reset  <= 1'b1;
    end else if (!alarm_active) begin
      // Alarm gone: abandon the game, keep the score on display
      state        <= S_IDLE;
      rn           <= '0;
      alarm_off    <= 1'b0;
      timer_enable <= 1'b0;
      timer_reset  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          hits        <= '0;
          misses      <= '0;
          timer_reset <= 1'b1;
          state       <= S_RELEASE;
        end
        S_RELEASE: begin
          // A button still held from the last round must not score
          if (!any_btn) begin
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (any_btn) begin
            state <= S_RELEASE;
          end else if (gap_cnt == GAP_W'(1)) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Mole 0 does not exist; keep stepping until 1..3 comes up
          if (pick != '0) begin
            rn           <= pick;
            timer_reset  <= 1'b0;
            timer_enable <= 1'b1;
            state        <= S_ARM;
          end
        end
        S_ARM: begin
          // Timer done may be stale from the last round; skip it here
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            rn           <= '0;
            timer_enable <= 1'b0;
            timer_reset  <= 1'b1;
            if (right) begin
              hits <= hits_inc;
              if (hits_inc == 4'(HITS_NEEDED)) begin
                alarm_off <= 1'b1;
                state     <= S_WIN;
              end else begin
                state <= S_RELEASE;
              end
            end else begin
              hits <= '0;
              if (misses != 4'd15) begin
                misses <= misses + 4'd1;
              end
              state <= S_RELEASE;
            end
          end
        end
        S_WIN: begin
          alarm_off   <= 1'b1;
          timer_reset <= 1'b1;
          rn          <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Mole display: one-hot on rn while a round is live
  always_comb begin
    led = 4'b0000;
    if (state == S_ARM || state == S_WAIT) begin
      led[rn] = 1'b1;
    end
  end

endmodule

// File: tb/tb_wm_round_ctrl.sv
// Directed bench for wm_round_ctrl with default parameters (5 hits, 50-cycle gap, seed A5).
// Mole sequence from seed A5: 2,1,2,1(two LOAD cycles),3,... hand-derived from the taps.
// Edges to first ARM after start = 53 (IDLE, RELEASE, 50 GAP, LOAD); between rounds = 52.
module tb_wm_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       alarm_active;
  logic       B1, B2, B3, B4;
  logic       right, done;
  logic [1:0] rn;
  logic       timer_reset, timer_enable;
  logic [3:0] led, hits, misses;
  logic       alarm_off;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wm_round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .alarm_active (alarm_active),
    .B1           (B1),
    .B2           (B2),
    .B3           (B3),
    .B4           (B4),
    .right        (right),
    .done         (done),
    .rn           (rn),
    .timer_reset  (timer_reset),
    .timer_enable (timer_enable),
    .led          (led),
    .hits         (hits),
    .misses       (misses),
    .alarm_off    (alarm_off)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; alarm_active = 1'b0;
    B1 = 1'b0; B2 = 1'b0; B3 = 1'b0; B4 = 1'b0;
    right = 1'b0; done = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Count edges until the timer is released (ARM); bounded
  task automatic wait_arm(output int n);
    n = 0;
    while (timer_reset !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (timer_reset !== 1'b0) begin
      failures++;
      $display("FAIL wait_arm_timeout got timer_reset=%b after %0d cycles exp 0", timer_reset, n);
    end
  endtask

  // Play one round: wait for ARM, capture display, move to WAIT, deliver verdict
  task automatic run_round(input logic hit, output int n, output logic [1:0] r,
                           output logic [3:0] l, output logic te);
    wait_arm(n);
    r = rn; l = led; te = timer_enable;
    step();
    done = 1'b1; right = hit;
    step();
    done = 1'b0; right = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; alarm_active = 1'b1;
    B1 = 1'b0; B2 = 1'b0; B3 = 1'b0; B4 = 1'b0; right = 1'b0; done = 1'b0;
    step(); step();
    checks++; if (rn !== 2'd0) begin failures++; $display("FAIL reset_rn got=%0d exp=0", rn); end
    checks++; if (led !== 4'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", led); end
    checks++; if (hits !== 4'd0) begin failures++; $display("FAIL reset_hits got=%0d exp=0", hits); end
    checks++; if (misses !== 4'd0) begin failures++; $display("FAIL reset_misses got=%0d exp=0", misses); end
    checks++; if (alarm_off !== 1'b0) begin failures++; $display("FAIL reset_alarm_off got=%b exp=0", alarm_off); end
    checks++; if (timer_enable !== 1'b0) begin failures++; $display("FAIL reset_timer_enable got=%b exp=0", timer_enable); end
    checks++; if (timer_reset !== 1'b1) begin failures++; $display("FAIL reset_timer_reset got=%b exp=1", timer_reset); end
    alarm_active = 1'b0; reset = 1'b0;
  endtask

  task automatic test_first_round();
    int n;
    apply_reset();
    alarm_active = 1'b1;
    wait_arm(n);
    checks++; if (n != 53) begin failures++; $display("FAIL first_latency got=%0d exp=53", n); end
    checks++; if (rn !== 2'd2) begin failures++; $display("FAIL first_rn got=%0d exp=2", rn); end
    checks++; if (led !== 4'b0100) begin failures++; $display("FAIL first_led got=%b exp=0100", led); end
    checks++; if (timer_enable !== 1'b1) begin failures++; $display("FAIL first_enable got=%b exp=1", timer_enable); end
    step();
    checks++; if (timer_reset !== 1'b0 || led !== 4'b0100) begin failures++; $display("FAIL first_wait got tr=%b led=%b exp tr=0 led=0100", timer_reset, led); end
    done = 1'b1; right = 1'b1;
    step();
    done = 1'b0; right = 1'b0;
    checks++; if (hits !== 4'd1) begin failures++; $display("FAIL first_hits got=%0d exp=1", hits); end
    checks++; if (rn !== 2'd0 || led !== 4'h0) begin failures++; $display("FAIL first_exit_display got rn=%0d led=%b exp 0/0000", rn, led); end
    checks++; if (timer_enable !== 1'b0 || timer_reset !== 1'b1) begin failures++; $display("FAIL first_exit_timer got en=%b tr=%b exp 0/1", timer_enable, timer_reset); end
  endtask

  task automatic test_win();
    int n; logic [1:0] r; logic [3:0] l; logic te;
    logic [1:0] exp_rn [5] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd3};
    int         exp_n  [5] = '{53, 52, 52, 53, 52};
    apply_reset();
    alarm_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_round(1'b1, n, r, l, te);
      checks++; if (r !== exp_rn[i]) begin failures++; $display("FAIL win_rn[%0d] got=%0d exp=%0d", i, r, exp_rn[i]); end
      checks++; if (n != exp_n[i]) begin failures++; $display("FAIL win_latency[%0d] got=%0d exp=%0d", i, n, exp_n[i]); end
      checks++; if (l !== (4'b0001 << exp_rn[i])) begin failures++; $display("FAIL win_led[%0d] got=%b", i, l); end
      checks++; if (hits !== 4'(i + 1)) begin failures++; $display("FAIL win_hits[%0d] got=%0d exp=%0d", i, hits, i + 1); end
      checks++; if (alarm_off !== (i == 4)) begin failures++; $display("FAIL win_alarm_off[%0d] got=%b", i, alarm_off); end
    end
    checks++; if (timer_enable !== 1'b0) begin failures++; $display("FAIL win_enable got=%b exp=0", timer_enable); end
    step(); step();
    checks++; if (alarm_off !== 1'b1 || rn !== 2'd0) begin failures++; $display("FAIL win_hold got off=%b rn=%0d exp 1/0", alarm_off, rn); end
    alarm_active = 1'b0;
    step();
    checks++; if (alarm_off !== 1'b0) begin failures++; $display("FAIL win_drop_alarm_off got=%b exp=0", alarm_off); end
    checks++; if (hits !== 4'd5 || timer_reset !== 1'b1) begin failures++; $display("FAIL win_drop_state got hits=%0d tr=%b exp 5/1", hits, timer_reset); end
  endtask

  task automatic test_timeout();
    int n; logic [1:0] r; logic [3:0] l; logic te;
    apply_reset();
    alarm_active = 1'b1;
    for (int i = 0; i < 3; i++) run_round(1'b1, n, r, l, te);
    checks++; if (hits !== 4'd3) begin failures++; $display("FAIL to_pre_hits got=%0d exp=3", hits); end
    run_round(1'b0, n, r, l, te);
    checks++; if (r !== 2'd1 || n != 53) begin failures++; $display("FAIL to_round got rn=%0d n=%0d exp 1/53", r, n); end
    checks++; if (hits !== 4'd0) begin failures++; $display("FAIL to_hits got=%0d exp=0", hits); end
    checks++; if (misses !== 4'd1) begin failures++; $display("FAIL to_misses got=%0d exp=1", misses); end
    run_round(1'b1, n, r, l, te);
    checks++; if (r !== 2'd3 || n != 52) begin failures++; $display("FAIL to_next_round got rn=%0d n=%0d exp 3/52", r, n); end
    checks++; if (hits !== 4'd1 || misses !== 4'd1) begin failures++; $display("FAIL to_next_score got h=%0d m=%0d exp 1/1", hits, misses); end
  endtask

  task automatic test_hold_button();
    int n; logic bad;
    apply_reset();
    alarm_active = 1'b1;
    wait_arm(n);
    step();
    done = 1'b1; right = 1'b1; B2 = 1'b1;
    step();
    done = 1'b0; right = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (timer_reset !== 1'b1 || rn !== 2'd0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL hold_no_round got armed=%b exp=0", bad); end
    B2 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    B3 = 1'b1;
    step();
    B3 = 1'b0;
    wait_arm(n);
    checks++; if (n != 52) begin failures++; $display("FAIL hold_gap_restart got=%0d exp=52", n); end
    checks++; if (rn !== 2'd1) begin failures++; $display("FAIL hold_rn got=%0d exp=1", rn); end
  endtask

  task automatic test_stale_done();
    int n;
    apply_reset();
    alarm_active = 1'b1;
    wait_arm(n);
    done = 1'b1; right = 1'b0;
    step();
    checks++; if (misses !== 4'd0) begin failures++; $display("FAIL stale_misses got=%0d exp=0", misses); end
    checks++; if (timer_enable !== 1'b1 || led !== 4'b0100) begin failures++; $display("FAIL stale_live got en=%b led=%b exp 1/0100", timer_enable, led); end
    right = 1'b1;
    step();
    done = 1'b0; right = 1'b0;
    checks++; if (hits !== 4'd1 || misses !== 4'd0) begin failures++; $display("FAIL stale_verdict got h=%0d m=%0d exp 1/0", hits, misses); end
  endtask

  task automatic test_abort_and_reset();
    int n; logic [1:0] r; logic [3:0] l; logic te;
    apply_reset();
    alarm_active = 1'b1;
    run_round(1'b1, n, r, l, te);
    wait_arm(n);
    step();
    alarm_active = 1'b0;
    step();
    checks++; if (timer_reset !== 1'b1 || timer_enable !== 1'b0) begin failures++; $display("FAIL abort_timer got tr=%b en=%b exp 1/0", timer_reset, timer_enable); end
    checks++; if (led !== 4'h0 || rn !== 2'd0) begin failures++; $display("FAIL abort_display got led=%b rn=%0d exp 0000/0", led, rn); end
    checks++; if (hits !== 4'd1) begin failures++; $display("FAIL abort_hits_kept got=%0d exp=1", hits); end
    step(); step();
    alarm_active = 1'b1;
    step();
    checks++; if (hits !== 4'd0) begin failures++; $display("FAIL restart_hits_clear got=%0d exp=0", hits); end
    wait_arm(n);
    checks++; if (n != 52 || rn !== 2'd2) begin failures++; $display("FAIL restart_round got n=%0d rn=%0d exp 52/2", n, rn); end
    step();
    reset = 1'b1;
    step();
    checks++; if (rn !== 2'd0 || led !== 4'h0 || timer_reset !== 1'b1 || timer_enable !== 1'b0) begin failures++; $display("FAIL midreset_outputs got rn=%0d led=%b tr=%b en=%b", rn, led, timer_reset, timer_enable); end
    checks++; if (hits !== 4'd0 || misses !== 4'd0 || alarm_off !== 1'b0) begin failures++; $display("FAIL midreset_score got h=%0d m=%0d off=%b", hits, misses, alarm_off); end
    reset = 1'b0;
    wait_arm(n);
    checks++; if (n != 53 || rn !== 2'd2) begin failures++; $display("FAIL midreset_seed got n=%0d rn=%0d exp 53/2", n, rn); end
  endtask

  task automatic test_miss_saturation();
    int n; logic [1:0] r; logic [3:0] l; logic te;
    apply_reset();
    alarm_active = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_round(1'b0, n, r, l, te);
      if (i >= 14) begin
        checks++; if (misses !== 4'd15) begin failures++; $display("FAIL sat_misses[%0d] got=%0d exp=15", i, misses); end
      end
    end
    checks++; if (hits !== 4'd0) begin failures++; $display("FAIL sat_hits got=%0d exp=0", hits); end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_win();
    test_timeout();
    test_hold_button();
    test_stale_done();
    test_abort_and_reset();
    test_miss_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
